// File: rtl/wb_bus_pkg.sv
// Shared Wishbone constants and interconnect state encoding.
package wb_bus_pkg;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        DERR = 2'd2
    } bus_state_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: on load, registers the first requester after the last grant.
module wb_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          load,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  grant_oh
);
    logic [IW-1:0] last_reg;
    logic [IW-1:0] pick;

    // Scan from farthest to nearest so the closest requester after last_reg wins.
    always_comb begin
        pick = last_reg;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last_reg) + k) % N]) begin
                pick = IW'((int'(last_reg) + k) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg  <= IW'(N - 1);
            grant_idx <= '0;
            grant_oh  <= N'(1);
        end else if (load && |req) begin
            last_reg  <= pick;
            grant_idx <= pick;
            grant_oh  <= N'(1) << pick;
        end
    end
endmodule

// File: rtl/wb_shared_bus.sv
// Parametrised Wishbone shared-bus interconnect with round-robin arbitration and decode errors.
// Watchdog timeout responses are built only when WB_SHARED_BUS_TIMEOUT_EN is defined.
module wb_shared_bus
    import wb_bus_pkg::*;
#(
    parameter int                        NUM_MASTERS    = 4,
    parameter int                        NUM_SLAVES     = 8,
    parameter logic [32*NUM_SLAVES-1:0]  SLV_ADDR       = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  SLV_MASK       = {NUM_SLAVES{32'h0}},
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [ADR_W*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [DAT_W*NUM_MASTERS-1:0]   m_dat_i,
    input  logic [SEL_W*NUM_MASTERS-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]         m_we_i,
    input  logic [NUM_MASTERS-1:0]         m_cyc_i,
    input  logic [NUM_MASTERS-1:0]         m_stb_i,
    output logic [DAT_W-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic [NUM_MASTERS-1:0]         m_err_o,
    output logic [NUM_MASTERS-1:0]         m_rty_o,
    output logic [ADR_W-1:0]               s_adr_o,
    output logic [DAT_W-1:0]               s_dat_o,
    output logic [SEL_W-1:0]               s_sel_o,
    output logic                           s_we_o,
    output logic [NUM_SLAVES-1:0]          s_cyc_o,
    output logic [NUM_SLAVES-1:0]          s_stb_o,
    input  logic [DAT_W*NUM_SLAVES-1:0]    s_dat_i,
    input  logic [NUM_SLAVES-1:0]          s_ack_i,
    input  logic [NUM_SLAVES-1:0]          s_err_i,
    input  logic [NUM_SLAVES-1:0]          s_rty_i
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    bus_state_t             state_reg, state_next;
    logic                   arb_load;
    logic [IW-1:0]          owner;
    logic [NUM_MASTERS-1:0] owner_oh;

    wb_rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .req       (m_cyc_i),
        .load      (arb_load),
        .grant_idx (owner),
        .grant_oh  (owner_oh)
    );

    logic [ADR_W-1:0] own_adr;
    logic             own_cyc, own_stb;

    assign own_adr = m_adr_i[ADR_W*owner +: ADR_W];
    assign own_cyc = m_cyc_i[owner];
    assign own_stb = own_cyc & m_stb_i[owner];
    assign s_adr_o = own_adr;
    assign s_dat_o = m_dat_i[DAT_W*owner +: DAT_W];
    assign s_sel_o = m_sel_i[SEL_W*owner +: SEL_W];
    assign s_we_o  = m_we_i[owner];

    logic [NUM_SLAVES-1:0] match, slv_oh;
    logic [SW-1:0]         slv_idx;
    logic                  hit;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
        assign match[gi] = ((own_adr & SLV_MASK[32*gi +: 32]) ==
                            (SLV_ADDR[32*gi +: 32] & SLV_MASK[32*gi +: 32]));
    end

    // Descending scan leaves the lowest matching index selected on overlap.
    always_comb begin
        slv_idx = '0;
        hit     = 1'b0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (match[k]) begin
                slv_idx = SW'(k);
                hit     = 1'b1;
            end
        end
    end

    assign slv_oh = hit ? (NUM_SLAVES'(1) << slv_idx) : '0;

    logic active, resp_ack, resp_err, resp_rty, any_resp, wd_hit;

    assign active   = (state_reg == OWN) && own_stb && hit;
    assign resp_ack = active & s_ack_i[slv_idx];
    assign resp_err = active & s_err_i[slv_idx];
    assign resp_rty = active & s_rty_i[slv_idx];
    assign any_resp = resp_ack | resp_err | resp_rty;
    assign m_dat_o  = s_dat_i[DAT_W*slv_idx +: DAT_W];

`ifdef WB_SHARED_BUS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_reg, wd_next;

    assign wd_hit  = active && (wd_reg == WD_W'(TIMEOUT_CYCLES));
    assign wd_next = (!active || any_resp || wd_hit) ? '0 : wd_reg + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wd_reg <= '0;
        else          wd_reg <= wd_next;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign wd_hit         = 1'b0;
`endif

    // A slave response in the timeout cycle takes precedence over the watchdog error.
    logic err_owner;
    assign err_owner = resp_err | (wd_hit & ~any_resp) | (state_reg == DERR);

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
        assign m_ack_o[gi] = owner_oh[gi] & resp_ack;
        assign m_err_o[gi] = owner_oh[gi] & err_owner;
        assign m_rty_o[gi] = owner_oh[gi] & resp_rty;
    end

    assign s_cyc_o = ((state_reg == OWN) && own_cyc) ? slv_oh : '0;
    assign s_stb_o = ((state_reg == OWN) && own_stb && !wd_hit) ? slv_oh : '0;

    always_comb begin
        state_next = state_reg;
        arb_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|m_cyc_i) begin
                    arb_load   = 1'b1;
                    state_next = OWN;
                end
            end
            OWN: begin
                if (!own_cyc) begin
                    arb_load   = 1'b1;
                    state_next = (|m_cyc_i) ? OWN : IDLE;
                end else if (own_stb && !hit) begin
                    state_next = DERR;
                end
            end
            DERR:    state_next = OWN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= IDLE;
        else          state_reg <= state_next;
    end
endmodule

// File: tb/tb_wb_shared_bus.sv
// Self-checking bench for wb_shared_bus: 4 masters, 2 slaves, scoreboarded responses.
module tb_wb_shared_bus;
    localparam int NM = 4;
    localparam int NS = 2;

    logic            clk, rst_n;
    logic [32*NM-1:0] m_adr, m_dat;
    logic [4*NM-1:0]  m_sel;
    logic [NM-1:0]    m_we, m_cyc, m_stb;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [32*NS-1:0] s_dat;
    logic [NS-1:0]    s_ack, s_err, s_rty;

    wb_shared_bus #(
        .NUM_MASTERS    (NM),
        .NUM_SLAVES     (NS),
        .SLV_ADDR       ({32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK       ({32'hF000_0000, 32'hFFFF_8000}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i (clk), .rst_n_i (rst_n),
        .m_adr_i (m_adr), .m_dat_i (m_dat), .m_sel_i (m_sel), .m_we_i (m_we),
        .m_cyc_i (m_cyc), .m_stb_i (m_stb),
        .m_dat_o (m_dat_o), .m_ack_o (m_ack_o), .m_err_o (m_err_o), .m_rty_o (m_rty_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o), .s_we_o (s_we_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o),
        .s_dat_i (s_dat), .s_ack_i (s_ack), .s_err_i (s_err), .s_rty_i (s_rty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave models: slave0 acks one cycle after stb; slave1 acks on demand.
    logic       ack0, ack1, s1_auto, s1_delay_en;
    logic [9:0] s1_cnt;

    always @(posedge clk) begin
        ack0   <= s_stb_o[0] & ~ack0;
        ack1   <= s1_auto ? (s_stb_o[1] & ~ack1) : (s1_delay_en && s_stb_o[1] && s1_cnt == 10'd15);
        s1_cnt <= s_stb_o[1] ? s1_cnt + 10'd1 : 10'd0;
    end

    assign s_dat = {32'hCAFE_0001, 32'hDEAD_BEEF};
    assign s_ack = {ack1, ack0};
    assign s_err = '0;
    assign s_rty = '0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  code;   // {rty, err, ack}; 0 means no response within budget
        logic [31:0] dat;
        int          lat;    // 0 means latency not checked
        bit          chk_stb;
        logic [1:0]  stb;
    } exp_t;

    exp_t sb[$];
    int   gq[$];

    task automatic expect_resp(input logic [2:0] code, input logic [31:0] dat, input int lat,
                               input bit chk_stb, input logic [1:0] stb);
        exp_t e;
        e.code = code; e.dat = dat; e.lat = lat; e.chk_stb = chk_stb; e.stb = stb;
        sb.push_back(e);
    endtask

    task automatic xfer(input int m, input logic [31:0] adr, input int budget, input bit hold);
        exp_t        e;
        int          lat;
        logic [2:0]  code;
        logic [1:0]  stb_seen;
        logic [31:0] dat;
        m_adr[32*m +: 32] = adr;
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
        lat  = 0;
        code = 3'b000;
        while (code == 3'b000 && lat < budget) begin
            @(negedge clk);
            lat++;
            code = {m_rty_o[m], m_err_o[m], m_ack_o[m]};
        end
        stb_seen = s_stb_o;
        dat      = m_dat_o;
        e = sb.pop_front();
        $display("xfer m%0d adr %08h resp %b lat %0d dat %08h", m, adr, code, lat, dat);
        check("resp_code", code, e.code);
        if (code == 3'b001) check("rdata", dat, e.dat);
        if (e.lat != 0) check("latency", lat, e.lat);
        if (e.chk_stb) check("stb_in_resp", stb_seen, e.stb);
        if (hold) begin
            @(negedge clk);
            check("err_one_cycle", m_err_o[m], 1'b0);
            check("no_strobe_after_err", s_stb_o, 2'b00);
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        @(negedge clk);
    endtask

    // Two masters request together; winners are popped from gq in acknowledge order.
    task automatic contend(input int a, input int b);
        int          mm[2];
        logic [31:0] ad[2];
        int          t_ack[2];
        bit          done[2];
        int          n, w;
        mm[0] = a; mm[1] = b;
        ad[0] = 32'h0000_0100; ad[1] = 32'h0000_0200;
        for (int i = 0; i < 2; i++) begin
            m_adr[32*mm[i] +: 32] = ad[i];
            m_cyc[mm[i]] = 1'b1;
            m_stb[mm[i]] = 1'b1;
            done[i]  = 1'b0;
            t_ack[i] = 0;
        end
        n = 0;
        while (!(done[0] && done[1]) && n < 20) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 2; i++) begin
                if (!done[i] && m_ack_o[mm[i]]) begin
                    w = gq.pop_front();
                    $display("grant m%0d at cycle %0d adr %08h", mm[i], n, s_adr_o);
                    check("grant_order", mm[i], w);
                    check("grant_adr", s_adr_o, ad[i]);
                    check("nonowner_ack", m_ack_o[mm[1-i]], 1'b0);
                    done[i]  = 1'b1;
                    t_ack[i] = n;
                    m_cyc[mm[i]] = 1'b0;
                    m_stb[mm[i]] = 1'b0;
                end
            end
        end
        check("contend_done", {done[0], done[1]}, 2'b11);
        if (done[0] && done[1]) begin
            check("first_grant_lat", (t_ack[0] < t_ack[1]) ? t_ack[0] : t_ack[1], 2);
            check("no_idle_gap", (t_ack[0] < t_ack[1]) ? t_ack[1] - t_ack[0] : t_ack[0] - t_ack[1], 2);
        end
        m_cyc = '0;
        m_stb = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        m_adr = '0; m_dat = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0;
        s1_auto = 1'b0; s1_delay_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_cyc", s_cyc_o, 2'b00);
        check("rst_s_stb", s_stb_o, 2'b00);
        check("rst_m_resp", {m_ack_o, m_err_o, m_rty_o}, 12'h000);
        rst_n = 1'b1;
        @(negedge clk);

        gq.push_back(0); gq.push_back(2);
        contend(0, 2);
        gq.push_back(3); gq.push_back(0);
        contend(3, 0);

        expect_resp(3'b001, 32'hDEAD_BEEF, 2, 1'b1, 2'b01);
        xfer(0, 32'h0000_0010, 20, 1'b0);

        s1_auto = 1'b1;
        expect_resp(3'b001, 32'hCAFE_0001, 2, 1'b1, 2'b10);
        xfer(3, 32'h1000_0040, 20, 1'b0);
        s1_auto = 1'b0;

        expect_resp(3'b010, 32'h0, 2, 1'b1, 2'b00);
        xfer(1, 32'h9000_0000, 20, 1'b1);

`ifdef WB_SHARED_BUS_TIMEOUT_EN
        expect_resp(3'b010, 32'h0, 17, 1'b1, 2'b00);
        xfer(1, 32'h1000_0000, 40, 1'b0);
`else
        expect_resp(3'b000, 32'h0, 0, 1'b0, 2'b00);
        xfer(1, 32'h1000_0000, 1000, 1'b0);
`endif

        s1_delay_en = 1'b1;
        expect_resp(3'b001, 32'hCAFE_0001, 17, 1'b0, 2'b00);
        xfer(2, 32'h1000_0008, 40, 1'b0);
        s1_delay_en = 1'b0;

        // Reset in the middle of a stalled transfer.
        m_adr[32*2 +: 32] = 32'h1000_0004;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_stb", s_stb_o, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-transfer: s_cyc %b s_stb %b", s_cyc_o, s_stb_o);
        check("async_rst_cyc", s_cyc_o, 2'b00);
        check("async_rst_stb", s_stb_o, 2'b00);
        check("async_rst_ack", m_ack_o, 4'b0000);
        m_cyc = '0;
        m_stb = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        gq.push_back(0); gq.push_back(2);
        contend(2, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
